// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matmul_seq_ctrl
// Brief    : Job sequencer for the weight-stationary NxN systolic matrix unit
//            (load B, stream A, collect C). Define MATMUL_SEQ_PERF_EN to add
//            the perf_cycles busy-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_seq_ctrl #(
    parameter int N      = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W:0]         cfg_m,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    w_rd_en,
    output logic [$clog2(N)-1:0]    w_rd_addr,
    input  logic [N*DATA_W-1:0]     w_rd_data,
    output logic                    a_rd_en,
    output logic [ADDR_W-1:0]       a_rd_addr,
    input  logic [N*DATA_W-1:0]     a_rd_data,
    output logic                    arr_clear,
    output logic                    arr_w_load,
    output logic [$clog2(N)-1:0]    arr_w_row,
    output logic [N*DATA_W-1:0]     arr_w_data,
    output logic                    arr_a_valid,
    output logic [N*DATA_W-1:0]     arr_a_data,
    input  logic                    arr_c_valid,
    input  logic [N*DATA_W-1:0]     arr_c_data,
    output logic                    c_wr_en,
    output logic [ADDR_W-1:0]       c_wr_addr,
    output logic [N*DATA_W-1:0]     c_wr_data
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]             perf_cycles
`endif
);

    localparam int                 c_wa_w   = $clog2(N);
    localparam logic [c_wa_w-1:0]  c_w_last = c_wa_w'(N - 1);
    localparam logic [ADDR_W:0]    c_m_max  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_m_last;
    logic [ADDR_W-1:0]  r_wr_cnt;
    logic               r_cap_done;

    wire w_accept   = (r_state == IDLE) && start;
    wire w_bad_m    = (cfg_m == '0) || (cfg_m > c_m_max);
    wire w_capture  = ((r_state == STREAM) || (r_state == DRAIN)) && arr_c_valid && !r_cap_done;
    wire w_to_done  = (r_state == DRAIN) && r_cap_done;

    // Read data arrives one cycle after the read; forward it alongside the
    // delayed strobe and hold the bus at zero otherwise.
    assign arr_w_data = arr_w_load  ? w_rd_data : '0;
    assign arr_a_data = arr_a_valid ? a_rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_m_last    <= '0;
            r_wr_cnt    <= '0;
            r_cap_done  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            w_rd_en     <= 1'b0;
            w_rd_addr   <= '0;
            a_rd_en     <= 1'b0;
            a_rd_addr   <= '0;
            arr_clear   <= 1'b0;
            arr_w_load  <= 1'b0;
            arr_w_row   <= '0;
            arr_a_valid <= 1'b0;
            c_wr_en     <= 1'b0;
            c_wr_addr   <= '0;
            c_wr_data   <= '0;
        end else begin
            arr_clear   <= 1'b0;
            done        <= 1'b0;
            c_wr_en     <= 1'b0;
            arr_w_load  <= w_rd_en;
            arr_w_row   <= w_rd_en ? w_rd_addr : '0;
            arr_a_valid <= a_rd_en;

            // Completion is a sticky flag so M = 2^ADDR_W works with the wrapping count.
            if (w_capture) begin
                c_wr_en   <= 1'b1;
                c_wr_addr <= r_wr_cnt;
                c_wr_data <= arr_c_data;
                r_wr_cnt  <= r_wr_cnt + ADDR_W'(1);
                if (r_wr_cnt == r_m_last) begin
                    r_cap_done <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        r_wr_cnt   <= '0;
                        r_cap_done <= 1'b0;
                        r_m_last   <= cfg_m[ADDR_W-1:0] - ADDR_W'(1);
                        if (cfg_m == '0) begin
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else if (cfg_m > c_m_max) begin
                            err     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            arr_clear <= 1'b1;
                            w_rd_en   <= 1'b1;
                            w_rd_addr <= '0;
                            r_state   <= LOAD_W;
                        end
                    end
                end
                LOAD_W: begin
                    if (w_rd_addr == c_w_last) begin
                        w_rd_en   <= 1'b0;
                        w_rd_addr <= '0;
                        a_rd_en   <= 1'b1;
                        a_rd_addr <= '0;
                        r_state   <= STREAM;
                    end else begin
                        w_rd_addr <= w_rd_addr + c_wa_w'(1);
                    end
                end
                STREAM: begin
                    if (a_rd_addr == r_m_last) begin
                        a_rd_en   <= 1'b0;
                        a_rd_addr <= '0;
                        r_state   <= DRAIN;
                    end else begin
                        a_rd_addr <= a_rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (r_cap_done) begin
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] r_perf_cnt;
    wire  [31:0] w_perf_next = (r_perf_cnt == 32'hFFFF_FFFF) ? r_perf_cnt : r_perf_cnt + 32'd1;

    // r_perf_cnt holds the busy-cycle index of the current cycle, so the value
    // published on entry to DONE already includes the DONE cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt  <= '0;
            perf_cycles <= '0;
        end else begin
            if (w_accept) begin
                r_perf_cnt  <= 32'd1;
                perf_cycles <= w_bad_m ? 32'd1 : 32'd0;
            end else begin
                if (busy) begin
                    r_perf_cnt <= w_perf_next;
                end
                if (w_to_done) begin
                    perf_cycles <= w_perf_next;
                end
            end
        end
    end
`else
    wire w_unused_perf = &{1'b0, w_accept, w_bad_m, w_to_done};
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_ctrl.sv
`default_nettype none
// Directed testbench for matmul_seq_ctrl: buffer and array models around the
// sequencer, with hand-computed expected timing and result rows.
module tb_matmul_seq_ctrl;

    localparam int N = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int L = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  cfg_m;
    logic        busy, done, err;
    logic        w_rd_en, a_rd_en, arr_clear, arr_w_load, arr_a_valid, c_wr_en;
    logic [1:0]  w_rd_addr, arr_w_row;
    logic [7:0]  a_rd_addr, c_wr_addr;
    logic [63:0] w_rd_data, a_rd_data, arr_w_data, arr_a_data, arr_c_data, c_wr_data;
    logic        arr_c_valid;
    logic        stray;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] perf_cycles;
`endif

    matmul_seq_ctrl #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m),
        .busy(busy), .done(done), .err(err),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .arr_clear(arr_clear), .arr_w_load(arr_w_load), .arr_w_row(arr_w_row),
        .arr_w_data(arr_w_data), .arr_a_valid(arr_a_valid), .arr_a_data(arr_a_data),
        .arr_c_valid(arr_c_valid), .arr_c_data(arr_c_data),
        .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data)
`ifdef MATMUL_SEQ_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Buffers and a Q8.8 array model with latency L
    logic [63:0] bmem [4];
    logic [63:0] amem [256];
    logic [63:0] cmem [256];
    logic [15:0] wt [4][4];
    bit          pv [L];
    logic [63:0] pd [L];

    function automatic logic [63:0] mac(input logic [63:0] a);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            int acc;
            acc = 0;
            for (int k = 0; k < 4; k++)
                acc += int'($signed(a[k*16 +: 16])) * int'($signed(wt[k][j]));
            r[j*16 +: 16] = 16'(acc >>> 8);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= bmem[w_rd_addr];
        if (a_rd_en) a_rd_data <= amem[a_rd_addr];
        if (arr_clear) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) wt[i][j] <= '0;
        end else if (arr_w_load) begin
            for (int j = 0; j < 4; j++) wt[arr_w_row][j] <= arr_w_data[j*16 +: 16];
        end
        pv[0] <= arr_a_valid;
        pd[0] <= mac(arr_a_data);
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign arr_c_valid = pv[L-1] | stray;
    assign arr_c_data  = stray ? 64'hDEAD_BEEF_DEAD_BEEF : pd[L-1];

    int n_chk = 0;
    int n_err = 0;
    int n_wr, first_wr, last_wr, n_done, done_cyc, n_wrd, n_ard, first_ard, first_aval;
    int first_wload, max_a_addr, last_c_addr, clear_cyc, busy_first, busy_last;
    int addr_ok, err_done, post_busy, err_c1, idle_wr, idle_done, idle_busy;
    logic [63:0] rst_snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, done, err, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr, arr_clear,
                    arr_w_load, arr_w_row, arr_a_valid, c_wr_en, c_wr_addr})
               | arr_w_data | arr_a_data | c_wr_data;
    endfunction

    task automatic run_job(input logic [8:0] m, input int max_cyc, input int inj_cyc,
                           input int rst_cyc, input int stray_cyc);
        n_wr = 0; first_wr = -1; last_wr = -1; n_done = 0; done_cyc = -1;
        n_wrd = 0; n_ard = 0; first_ard = -1; first_aval = -1; first_wload = -1;
        max_a_addr = 0; last_c_addr = -1; clear_cyc = -1; busy_first = -1; busy_last = -1;
        addr_ok = 1; err_done = 0; post_busy = 1; err_c1 = -1;
        for (int i = 0; i < 256; i++) cmem[i] = '0;
        @(negedge clk);
        start = 1'b1;
        cfg_m = m;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin start = 1'b0; cfg_m = 9'd3; end
            if (inj_cyc > 0 && cyc == inj_cyc) begin start = 1'b1; cfg_m = 9'd9; end
            if (inj_cyc > 0 && cyc == inj_cyc + 1) start = 1'b0;
            stray = (stray_cyc > 0 && cyc == stray_cyc);
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                rst_snap = outs();
                rst = 1'b0;
                break;
            end
            if (busy) begin if (busy_first < 0) busy_first = cyc; busy_last = cyc; end
            if (arr_clear && clear_cyc < 0) clear_cyc = cyc;
            if (w_rd_en) n_wrd++;
            if (arr_w_load && first_wload < 0) first_wload = cyc;
            if (a_rd_en) begin
                n_ard++;
                if (first_ard < 0) first_ard = cyc;
                if (int'(a_rd_addr) > max_a_addr) max_a_addr = int'(a_rd_addr);
            end
            if (arr_a_valid && first_aval < 0) first_aval = cyc;
            if (c_wr_en) begin
                if (int'(c_wr_addr) != (n_wr % 256)) addr_ok = 0;
                cmem[c_wr_addr] = c_wr_data;
                n_wr++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                last_c_addr = int'(c_wr_addr);
            end
            if (done) begin n_done++; done_cyc = cyc; err_done = int'(err); end
            if (cyc == 1) err_c1 = int'(err);
            if (done_cyc > 0 && cyc == done_cyc + 1) post_busy = int'(busy);
            if (done_cyc > 0 && cyc == done_cyc + 3) break;
            if (rst_cyc > 0 && cyc == rst_cyc) rst = 1'b1;
        end
        start = 1'b0;
        stray = 1'b0;
    endtask

    task automatic idle_watch(input int ncyc);
        idle_wr = 0; idle_done = 0; idle_busy = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            stray = (c == 2 || c == 5 || c == 9);
            if (c_wr_en) idle_wr++;
            if (done) idle_done++;
            if (busy) idle_busy++;
        end
        stray = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_m = '0; stray = 1'b0;
        for (int r = 0; r < 4; r++) bmem[r] = 64'h0100 << (16 * r);
        for (int r = 0; r < 256; r++) amem[r] = 64'h0180_0180_0180_0180;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Identity B, A words 1.5
        run_job(9'd4, 60, 0, 0, 0);
        chk("t1_clear_cyc", clear_cyc, 1);
        chk("t1_wload_cyc", first_wload, 2);
        chk("t1_ard_cyc", first_ard, 5);
        chk("t1_aval_cyc", first_aval, 6);
        chk("t1_w_reads", n_wrd, 4);
        chk("t1_a_reads", n_ard, 4);
        chk("t1_first_wr", first_wr, 14);
        chk("t1_last_wr", last_wr, 17);
        chk("t1_n_wr", n_wr, 4);
        chk("t1_done_cyc", done_cyc, 18);
        chk("t1_n_done", n_done, 1);
        chk("t1_busy_span", {32'(busy_first), 32'(busy_last)}, {32'd1, 32'd18});
        chk("t1_post_busy", post_busy, 0);
        chk("t1_err", err_done, 0);
        chk("t1_addr_seq", addr_ok, 1);
        for (int r = 0; r < 4; r++) chk("t1_c_row", cmem[r], 64'h0180_0180_0180_0180);
`ifdef MATMUL_SEQ_PERF_EN
        chk("t1_perf", perf_cycles, 18);
`endif

        // Scaled B with an off-diagonal 0.5; stray valid during LOAD_W
        bmem[0] = 64'h0000_0000_0080_0200;
        bmem[1] = 64'h0000_0000_0200_0000;
        bmem[2] = 64'h0000_0200_0000_0000;
        bmem[3] = 64'h0200_0000_0000_0000;
        amem[0] = 64'h0100_0100_0100_0100;
        amem[1] = 64'h0200_0200_0200_0200;
        amem[2] = 64'h0300_0300_0300_0300;
        run_job(9'd3, 60, 0, 0, 3);
        chk("t2_n_wr", n_wr, 3);
        chk("t2_first_wr", first_wr, 14);
        chk("t2_done_cyc", done_cyc, 17);
        chk("t2_c_row0", cmem[0], 64'h0200_0200_0280_0200);
        chk("t2_c_row1", cmem[1], 64'h0400_0400_0500_0400);
        chk("t2_c_row2", cmem[2], 64'h0600_0600_0780_0600);

        // Start pulse mid-job is ignored
        for (int r = 0; r < 4; r++) bmem[r] = 64'h0100 << (16 * r);
        for (int r = 0; r < 4; r++) amem[r] = 64'h0180_0180_0180_0180;
        run_job(9'd4, 60, 5, 0, 0);
        chk("t3_n_wr", n_wr, 4);
        chk("t3_n_done", n_done, 1);
        chk("t3_done_cyc", done_cyc, 18);
        chk("t3_last_addr", last_c_addr, 3);
        chk("t3_a_reads", n_ard, 4);

        // Degenerate M=0
        run_job(9'd0, 20, 0, 0, 0);
        chk("t4_done_cyc", done_cyc, 1);
        chk("t4_err", err_done, 0);
        chk("t4_busy_span", {32'(busy_first), 32'(busy_last)}, {32'd1, 32'd1});
        chk("t4_no_access", {32'(n_wrd + n_ard), 32'(n_wr)}, 64'h0);
`ifdef MATMUL_SEQ_PERF_EN
        chk("t4_perf", perf_cycles, 1);
`endif

        // Rejected M=257
        run_job(9'd257, 20, 0, 0, 0);
        chk("t5_done_cyc", done_cyc, 1);
        chk("t5_err", err_done, 1);
        chk("t5_no_access", {32'(n_wrd + n_ard), 32'(n_wr)}, 64'h0);
        chk("t5_err_held", err, 1'b1);

        // Full-depth M=256; also clears err
        for (int r = 0; r < 256; r++) amem[r] = {4{16'(r)}};
        run_job(9'd256, 400, 0, 0, 0);
        chk("t6_err_cleared", err_c1, 0);
        chk("t6_a_reads", n_ard, 256);
        chk("t6_max_a_addr", max_a_addr, 255);
        chk("t6_n_wr", n_wr, 256);
        chk("t6_last_addr", last_c_addr, 255);
        chk("t6_done_cyc", done_cyc, 270);
        chk("t6_n_done", n_done, 1);
        chk("t6_addr_seq", addr_ok, 1);
        chk("t6_c_row128", cmem[128], 64'h0080_0080_0080_0080);
        chk("t6_c_row255", cmem[255], 64'h00FF_00FF_00FF_00FF);

        // Reset mid-STREAM, stray valids while idle, then a fresh M=2 job
        for (int r = 0; r < 4; r++) amem[r] = 64'h0180_0180_0180_0180;
        run_job(9'd4, 60, 0, 7, 0);
        chk("t7_rst_outputs", rst_snap, 64'h0);
        chk("t7_rst_no_done", n_done, 0);
        idle_watch(20);
        chk("t7_idle_wr", idle_wr, 0);
        chk("t7_idle_done_busy", {32'(idle_done), 32'(idle_busy)}, 64'h0);
        amem[0] = 64'h0300_0300_0300_0300;
        amem[1] = 64'h0340_0340_0340_0340;
        run_job(9'd2, 60, 0, 0, 0);
        chk("t7_n_wr", n_wr, 2);
        chk("t7_done_cyc", done_cyc, 16);
        chk("t7_c_row0", cmem[0], 64'h0300_0300_0300_0300);
        chk("t7_c_row1", cmem[1], 64'h0340_0340_0340_0340);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
